// File: rtl/float_argmax.sv
`default_nettype none

// ============================================================================
// Module   : float_argmax (with companion greater_than comparator)
// Purpose  : Streaming arg-max stage fed by the NN_CORE output layer. It reads
//            N_CLASS sign-magnitude floats in index order and returns the
//            largest value and its 0-based index.
// Ports    : clk, rst_n (async, active low)
//            start              - one-cycle run request, seen only when idle
//            in_data/in_valid   - element stream; in_ready high in S_FETCH
//            max_val/max_idx    - result, stable while out_valid
//            out_valid/out_ready- result handshake
//            busy               - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================

// Codebase float format; normally provided by extern.v.
`ifndef D_LEN
  `define D_LEN 16
`endif
`ifndef E_bit
  `define E_bit 5
`endif
`ifndef F_bit
  `define F_bit 10
`endif

// ----------------------------------------------------------------------------
// greater_than: registered sign-magnitude compare, gt = (float_a > float_b)
// with the codebase tie rules. One cycle of latency.
// ----------------------------------------------------------------------------
module greater_than #(
  parameter int D_LEN = `D_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D_LEN-1:0] float_a,
  input  logic [D_LEN-1:0] float_b,
  output logic             gt
);

  logic             w_sign_a;
  logic             w_sign_b;
  logic [D_LEN-2:0] w_mag_a;
  logic [D_LEN-2:0] w_mag_b;
  logic             w_gt;

  assign w_sign_a = float_a[D_LEN-1];
  assign w_sign_b = float_b[D_LEN-1];
  assign w_mag_a  = float_a[D_LEN-2:0];
  assign w_mag_b  = float_b[D_LEN-2:0];

  always_comb begin
    w_gt = 1'b0;
    if (w_sign_a != w_sign_b) begin
      // Differing signs: the non-negative operand wins, so +0 beats -0.
      w_gt = ~w_sign_a;
    end else if (!w_sign_a) begin
      w_gt = (w_mag_a > w_mag_b);
    end else begin
      // Both negative: an equal magnitude also counts as "greater".
      w_gt = (w_mag_a <= w_mag_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt <= 1'b0;
    end else begin
      gt <= w_gt;
    end
  end

endmodule

// ----------------------------------------------------------------------------
// float_argmax
// ----------------------------------------------------------------------------
module float_argmax #(
  parameter int N_CLASS = 10,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [`D_LEN-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [`D_LEN-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_UPD   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_CLASS - 1);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic [`D_LEN-1:0] r_cand;
  logic [IDX_W-1:0]  r_cand_idx;
  logic              w_gt;

  // The comparator samples cand/max_val continuously; both are stable through
  // S_CMP, so its registered result is the decision needed in S_UPD.
  greater_than #(
    .D_LEN (`D_LEN)
  ) u_gt (
    .clk     (clk),
    .rst_n   (rst_n),
    .float_a (r_cand),
    .float_b (max_val),
    .gt      (w_gt)
  );

  assign in_ready  = (r_state == S_FETCH);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_cand_idx <= '0;
      max_val    <= '0;
      max_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (in_valid) begin
            if (r_cnt == '0) begin
              // First element seeds the running maximum.
              max_val <= in_data;
              max_idx <= '0;
              r_cnt   <= IDX_W'(1);
              if (N_CLASS == 1) begin
                r_state <= S_DONE;
              end
            end else begin
              r_cand     <= in_data;
              r_cand_idx <= r_cnt;
              r_cnt      <= r_cnt + IDX_W'(1);
              r_state    <= S_CMP;
            end
          end
        end

        S_CMP: begin
          r_state <= S_UPD;
        end

        S_UPD: begin
          if (w_gt) begin
            max_val <= r_cand;
            max_idx <= r_cand_idx;
          end
          if (r_cand_idx == C_LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_FETCH;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_float_argmax.sv
`default_nettype none

// ============================================================================
// Module   : tb_float_argmax
// Purpose  : Scoreboard bench for float_argmax (16-bit float, N_CLASS=4).
//            Stimulus pushes the hand-computed result of each run into a
//            queue; a monitor pops and compares on every result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_argmax;

  localparam int C_N     = 4;
  localparam int C_IDX_W = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       max_val;
  logic [C_IDX_W-1:0] max_idx;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  typedef struct packed {
    logic [15:0]        val;
    logic [C_IDX_W-1:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  float_argmax #(
    .N_CLASS (C_N),
    .IDX_W   (C_IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .max_val   (max_val),
    .max_idx   (max_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got val %h idx %0d, expected none", max_val, max_idx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_val", 32'(max_val), 32'(e.val));
        check("result_idx", 32'(max_idx), 32'(e.idx));
      end
    end
  end

  // One run of four elements: vec[15:0] is element 0. When abort_at is
  // nonzero, reset is asserted in that cycle and no result is expected.
  task automatic run_vec(input logic [63:0] vec, input logic [15:0] exp_val,
                         input logic [C_IDX_W-1:0] exp_idx, input int abort_at);
    int          k    = 0;
    int          lat  = 0;
    logic [10:0] pat  = '0;
    bit          done = 1'b0;
    exp_t        e;
    @(negedge clk);
    start = 1'b1;
    if (abort_at == 0) begin
      e.val = exp_val;
      e.idx = exp_idx;
      sb_q.push_back(e);
    end
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 11) pat[c-1] = in_ready;
      if (in_ready && k < C_N) begin
        in_data = vec[k*16 +: 16];
        k++;
      end
      if (abort_at != 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
        check("abort_max_val", 32'(max_val), 32'd0);
        check("abort_max_idx", 32'(max_idx), 32'd0);
        done = 1'b1;
      end else if (out_valid) begin
        lat  = c;
        done = 1'b1;
      end
    end
    in_data = 16'h7BFF;
    if (abort_at == 0) begin
      check("latency", 32'(lat), 32'd11);
      // in_ready expected in cycles t+1, t+2, t+5, t+8 only.
      check("in_ready_pattern", 32'(pat), 32'h093);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7BFF;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    check("reset_max_val", 32'(max_val), 32'd0);
    check("reset_max_idx", 32'(max_idx), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 1, 3, 2, -4
    run_vec({16'hC400, 16'h4000, 16'h4200, 16'h3C00}, 16'h4200, 4'd1, 0);
    // -3, -1, -2, -1: equal negatives move to the later index
    run_vec({16'hBC00, 16'hC000, 16'hBC00, 16'hC200}, 16'hBC00, 4'd3, 0);
    // 2, 2, 1, 2: equal positives keep the earlier index
    run_vec({16'h4000, 16'h3C00, 16'h4000, 16'h4000}, 16'h4000, 4'd0, 0);
    // -0, +0, -0, -0
    run_vec({16'h8000, 16'h8000, 16'h0000, 16'h8000}, 16'h0000, 4'd1, 0);

    // Result held while the consumer stalls; start is ignored meanwhile.
    @(posedge clk);
    #1 out_ready = 1'b0;
    run_vec({16'hC400, 16'h4000, 16'h4200, 16'h3C00}, 16'h4200, 4'd1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 1);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    start = 1'b0;
    check("hold_max_val", 32'(max_val), 32'h4200);
    check("hold_max_idx", 32'(max_idx), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_take_flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
    @(negedge clk);
    check("no_queued_start", {31'd0, busy}, 32'd0);

    // Reset during S_CMP of element 2, then a clean rerun.
    run_vec({16'hC400, 16'h4000, 16'h4200, 16'h3C00}, 16'h0000, 4'd0, 6);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec({16'hC400, 16'h4000, 16'h4200, 16'h3C00}, 16'h4200, 4'd1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
